// File: rtl/hs_monitor_pkg.sv
// hs_monitor_pkg: shared types and constants for the req/gnt handshake monitor.
package hs_monitor_pkg;

   localparam int unsigned HS_ERR_W = 3;

   typedef enum logic [HS_ERR_W-1:0] {
      ERR_NONE     = 3'd0,
      ERR_EARLY    = 3'd1,
      ERR_TIMEOUT  = 3'd2,
      ERR_DROP     = 3'd3,
      ERR_SPURIOUS = 3'd4
   } err_type_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HELD = 2'd2
   } hs_state_e;

endpackage

// File: rtl/hs_chan_fsm.sv
// hs_chan_fsm: one channel's handshake tracker. Emits a registered violation
// code for one cycle on the edge where the violation is decided.
module hs_chan_fsm
   import hs_monitor_pkg::*;
#(
   parameter int unsigned MIN_LAT = 1,
   parameter int unsigned MAX_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req,
   input  logic                gnt,
   output logic [HS_ERR_W-1:0] code
);

   localparam int unsigned   KW    = $clog2(MAX_LAT + 1);
   localparam logic [KW-1:0] MIN_K = KW'(MIN_LAT);
   localparam logic [KW-1:0] MAX_K = KW'(MAX_LAT);

   hs_state_e     state;
   logic [KW-1:0] k;

   // Channel FSM with latency counter; k is the number of edges since req was first seen.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         k     <= '0;
         code  <= ERR_NONE;
      end else begin
         code <= ERR_NONE;
         case (state)
            IDLE: begin
               if (req && gnt) begin
                  state <= HELD;
                  if (MIN_LAT != 0) code <= ERR_EARLY;
               end else if (req) begin
                  state <= WAIT;
                  k     <= KW'(1);
               end else if (gnt) begin
                  code <= ERR_SPURIOUS;
               end
            end
            WAIT: begin
               if (gnt) begin
                  // grant closes the transaction even if req drops on the same sample
                  state <= HELD;
                  k     <= '0;
                  code  <= (k < MIN_K) ? ERR_EARLY : ERR_NONE;
               end else if (!req) begin
                  state <= IDLE;
                  k     <= '0;
                  code  <= ERR_DROP;
               end else if (k == MAX_K) begin
                  state <= HELD;
                  k     <= '0;
                  code  <= ERR_TIMEOUT;
               end else begin
                  k <= k + KW'(1);
               end
            end
            HELD: begin
               if (!req) state <= IDLE;
            end
            default: begin
               state <= IDLE;
               k     <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/hs_monitor.sv
// hs_monitor: passive req/gnt latency monitor over NUM_CH channels.
// Define HS_MONITOR_SVA_EN to compile in per-channel concurrent assertions.
module hs_monitor
   import hs_monitor_pkg::*;
#(
   parameter int unsigned  NUM_CH  = 4,
   parameter int unsigned  MIN_LAT = 1,
   parameter int unsigned  MAX_LAT = 1,
   parameter int unsigned  CNT_W   = 16,
   localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_CH-1:0]   req,
   input  logic [NUM_CH-1:0]   gnt,
   input  logic                clr,
   output logic                err_vld,
   output logic [CH_W-1:0]     err_ch,
   output logic [HS_ERR_W-1:0] err_type,
   output logic [NUM_CH-1:0]   err_sticky,
   output logic [CNT_W-1:0]    err_cnt
);

   localparam int unsigned PC_W  = $clog2(NUM_CH + 1);
   localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

   logic [HS_ERR_W-1:0] code [NUM_CH];
   logic [NUM_CH-1:0]   viol_c;
   logic [CH_W-1:0]     ch_c;
   logic [HS_ERR_W-1:0] type_c;
   logic [PC_W-1:0]     pop_c;
   logic [CNT_W-1:0]    cnt_base_c;
   logic [SUM_W-1:0]    sum_c;
   logic [CNT_W-1:0]    cnt_nxt_c;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      hs_chan_fsm #(
         .MIN_LAT (MIN_LAT),
         .MAX_LAT (MAX_LAT)
      ) u_fsm (
         .clk  (clk),
         .rst  (rst),
         .req  (req[g]),
         .gnt  (gnt[g]),
         .code (code[g])
      );
      assign viol_c[g] = (code[g] != ERR_NONE);
   end

   // Lowest-index priority encode and popcount of this edge's violations.
   always_comb begin
      ch_c   = '0;
      type_c = '0;
      pop_c  = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (viol_c[i]) begin
            ch_c   = CH_W'(i);
            type_c = code[i];
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         pop_c = pop_c + PC_W'(viol_c[i]);
      end
   end

   // Saturating counter update; clr wipes the old count before new violations are added.
   always_comb begin
      cnt_base_c = clr ? '0 : err_cnt;
      sum_c      = SUM_W'(cnt_base_c) + SUM_W'(pop_c);
      cnt_nxt_c  = (sum_c > SUM_W'({CNT_W{1'b1}})) ? '1 : CNT_W'(sum_c);
   end

   // Registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_vld    <= 1'b0;
         err_ch     <= '0;
         err_type   <= '0;
         err_sticky <= '0;
         err_cnt    <= '0;
      end else begin
         err_vld    <= |viol_c;
         err_ch     <= ch_c;
         err_type   <= type_c;
         err_sticky <= (clr ? '0 : err_sticky) | viol_c;
         err_cnt    <= cnt_nxt_c;
      end
   end

`ifdef HS_MONITOR_SVA_EN
   for (genvar g = 0; g < NUM_CH; g++) begin : g_sva
      HS_EARLY: assert property (@(posedge clk) disable iff (rst) code[g] != ERR_EARLY)
         else $error("hs_monitor: early grant on channel %0d", g);
      HS_TIMEOUT: assert property (@(posedge clk) disable iff (rst) code[g] != ERR_TIMEOUT)
         else $error("hs_monitor: grant timeout on channel %0d", g);
      HS_DROP: assert property (@(posedge clk) disable iff (rst) code[g] != ERR_DROP)
         else $error("hs_monitor: request dropped on channel %0d", g);
      HS_SPURIOUS: assert property (@(posedge clk) disable iff (rst) code[g] != ERR_SPURIOUS)
         else $error("hs_monitor: spurious grant on channel %0d", g);
   end
`else
   // assertions compiled out; pure RTL build
`endif

endmodule

// File: tb/tb_hs_monitor.sv
// tb_hs_monitor: directed table-driven bench for hs_monitor (NUM_CH=4, MIN_LAT=1, MAX_LAT=3).
// A second instance with CNT_W=2 shares all stimulus to exercise counter saturation.
module tb_hs_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr;
   logic [3:0] req;
   logic [3:0] gnt;

   logic        err_vld,    vld_s;
   logic [1:0]  err_ch,     ch_s;
   logic [2:0]  err_type,   type_s;
   logic [3:0]  err_sticky, sticky_s;
   logic [15:0] err_cnt;
   logic [1:0]  cnt_s;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   hs_monitor #(.NUM_CH(4), .MIN_LAT(1), .MAX_LAT(3), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt), .clr(clr),
      .err_vld(err_vld), .err_ch(err_ch), .err_type(err_type),
      .err_sticky(err_sticky), .err_cnt(err_cnt)
   );

   hs_monitor #(.NUM_CH(4), .MIN_LAT(1), .MAX_LAT(3), .CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt), .clr(clr),
      .err_vld(vld_s), .err_ch(ch_s), .err_type(type_s),
      .err_sticky(sticky_s), .err_cnt(cnt_s)
   );

   typedef struct {
      logic        rst;
      logic        clr;
      logic [3:0]  req;
      logic [3:0]  gnt;
      logic        vld;
      logic [1:0]  ch;
      logic [2:0]  ty;
      logic [3:0]  st;
      logic [15:0] cnt;
      logic [1:0]  cs;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic c, input logic [3:0] rq,
                               input logic [3:0] gn, input logic v, input logic [1:0] ch,
                               input logic [2:0] ty, input logic [3:0] st,
                               input logic [15:0] cnt, input logic [1:0] cs);
      vec_t x;
      x.rst = r;  x.clr = c;  x.req = rq; x.gnt = gn;
      x.vld = v;  x.ch = ch;  x.ty = ty;  x.st = st; x.cnt = cnt; x.cs = cs;
      vecs.push_back(x);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic v, input logic [1:0] ch,
                        input logic [2:0] ty, input logic [3:0] st,
                        input logic [15:0] cnt, input logic [1:0] cs);
      tests++;
      if (err_vld !== v || err_ch !== ch || err_type !== ty || err_sticky !== st ||
          err_cnt !== cnt || vld_s !== v || sticky_s !== st || cnt_s !== cs) begin
         fails++;
         $display("FAIL %s: got vld=%b ch=%0d type=%0d sticky=%b cnt=%0d vld_s=%b sticky_s=%b cnt_s=%0d; want vld=%b ch=%0d type=%0d sticky=%b cnt=%0d cnt_s=%0d",
                  name, err_vld, err_ch, err_type, err_sticky, err_cnt, vld_s, sticky_s, cnt_s,
                  v, ch, ty, st, cnt, cs);
      end
   endtask

   task automatic drive(input logic r, input logic c, input logic [3:0] rq, input logic [3:0] gn);
      rst = r; clr = c; req = rq; gnt = gn;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected $finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Each row: inputs sampled on the next edge, outputs checked just after it.
      // Outputs lag the decision edge by one, so a row's expectation reflects the previous row.
      //   rst  clr  req      gnt      vld  ch  ty  sticky   cnt cs
      add(1, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);   // 0 reset
      add(1, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);   // 1 reset
      // ch0 compliant: req at k=0, gnt at k=2, drop
      add(0, 0, 4'b0001, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);   // 2
      add(0, 0, 4'b0001, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);   // 3
      add(0, 0, 4'b0001, 4'b0001, 0, 0, 0, 4'b0000, 0, 0);   // 4
      add(0, 0, 4'b0001, 4'b0001, 0, 0, 0, 4'b0000, 0, 0);   // 5
      add(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);   // 6
      add(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);   // 7
      // ch1 EARLY: req and gnt together
      add(0, 0, 4'b0010, 4'b0010, 0, 0, 0, 4'b0000, 0, 0);   // 8
      add(0, 0, 4'b0000, 4'b0000, 1, 1, 1, 4'b0010, 1, 1);   // 9
      add(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0010, 1, 1);   // 10
      // ch2 TIMEOUT: req held with no gnt
      add(0, 0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0010, 1, 1);   // 11 k=0
      add(0, 0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0010, 1, 1);   // 12
      add(0, 0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0010, 1, 1);   // 13
      add(0, 0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0010, 1, 1);   // 14 timeout decided
      add(0, 0, 4'b0100, 4'b0000, 1, 2, 2, 4'b0110, 2, 2);   // 15
      add(0, 0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0110, 2, 2);   // 16 still high, no error
      add(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0110, 2, 2);   // 17
      // clr, then ch0 DROP and ch3 SPURIOUS on the same edge
      add(0, 1, 4'b0001, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);   // 18
      add(0, 0, 4'b0000, 4'b1000, 0, 0, 0, 4'b0000, 0, 0);   // 19
      add(0, 0, 4'b0000, 4'b0000, 1, 0, 3, 4'b1001, 2, 2);   // 20
      add(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b1001, 2, 2);   // 21
      // back-to-back SPURIOUS on ch3; CNT_W=2 instance saturates
      add(0, 0, 4'b0000, 4'b1000, 0, 0, 0, 4'b1001, 2, 2);   // 22
      add(0, 0, 4'b0000, 4'b1000, 1, 3, 4, 4'b1001, 3, 3);   // 23
      add(0, 0, 4'b0000, 4'b0000, 1, 3, 4, 4'b1001, 4, 3);   // 24
      add(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b1001, 4, 3);   // 25
      // ch0 gnt at k=1 (= MIN_LAT) is legal
      add(0, 0, 4'b0001, 4'b0000, 0, 0, 0, 4'b1001, 4, 3);   // 26
      add(0, 0, 4'b0001, 4'b0001, 0, 0, 0, 4'b1001, 4, 3);   // 27
      add(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b1001, 4, 3);   // 28
      // ch1 gnt at k=3 (= MAX_LAT) is legal
      add(0, 0, 4'b0010, 4'b0000, 0, 0, 0, 4'b1001, 4, 3);   // 29
      add(0, 0, 4'b0010, 4'b0000, 0, 0, 0, 4'b1001, 4, 3);   // 30
      add(0, 0, 4'b0010, 4'b0000, 0, 0, 0, 4'b1001, 4, 3);   // 31
      add(0, 0, 4'b0010, 4'b0010, 0, 0, 0, 4'b1001, 4, 3);   // 32
      add(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b1001, 4, 3);   // 33
      add(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b1001, 4, 3);   // 34
      // ch2 gnt wins over simultaneous req drop; gnt lingering in HELD is silent
      add(0, 0, 4'b0100, 4'b0000, 0, 0, 0, 4'b1001, 4, 3);   // 35
      add(0, 0, 4'b0000, 4'b0100, 0, 0, 0, 4'b1001, 4, 3);   // 36
      add(0, 0, 4'b0000, 4'b0100, 0, 0, 0, 4'b1001, 4, 3);   // 37
      add(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b1001, 4, 3);   // 38

      drive(1, 0, 4'b0000, 4'b0000);
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].clr, vecs[i].req, vecs[i].gnt);
         step();
         check($sformatf("vec%0d", i), vecs[i].vld, vecs[i].ch, vecs[i].ty,
               vecs[i].st, vecs[i].cnt, vecs[i].cs);
      end

      // clr alone wipes sticky and count
      drive(0, 1, 4'b0000, 4'b0000);
      step();
      check("clr_only", 0, 0, 0, 4'b0000, 0, 0);

      // six SPURIOUS pulses on ch3: 16-bit count reaches 6, 2-bit count holds at 3
      drive(0, 0, 4'b0000, 4'b1000);
      for (int i = 0; i < 6; i++) step();
      drive(0, 0, 4'b0000, 4'b0000);
      step();
      check("six_spurious", 1, 3, 4, 4'b1000, 6, 3);

      // clr coincident with a new ch2 violation: the new one survives
      drive(0, 0, 4'b0000, 4'b0100);
      step();
      check("pre_clr", 0, 0, 0, 4'b1000, 6, 3);
      drive(0, 1, 4'b0000, 4'b0000);
      step();
      check("clr_with_viol", 1, 2, 4, 4'b0100, 1, 1);
      drive(0, 0, 4'b0000, 4'b0000);
      step();
      check("after_clr_viol", 0, 0, 0, 4'b0100, 1, 1);

      // rst while ch2 is in WAIT with k=2; the would-be DROP/SPURIOUS is suppressed
      drive(0, 0, 4'b0100, 4'b0000);
      step();
      drive(0, 0, 4'b0100, 4'b0000);
      step();
      drive(1, 0, 4'b0000, 4'b0001);
      step();
      check("rst_mid_wait", 0, 0, 0, 4'b0000, 0, 0);
      drive(0, 0, 4'b0000, 4'b0000);
      step();
      check("post_rst_idle", 0, 0, 0, 4'b0000, 0, 0);

      // compliant handshake after reset stays clean
      drive(0, 0, 4'b0001, 4'b0000);
      step();
      drive(0, 0, 4'b0001, 4'b0001);
      step();
      check("post_rst_gnt", 0, 0, 0, 4'b0000, 0, 0);
      drive(0, 0, 4'b0000, 4'b0000);
      step();
      check("post_rst_close", 0, 0, 0, 4'b0000, 0, 0);
      step();
      check("post_rst_quiet", 0, 0, 0, 4'b0000, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hs_monitor.md
# hs_monitor

Synthesizable, parametrised req/gnt handshake protocol monitor. Watches NUM_CH independent request/grant channels. Checks that each grant arrives within a configurable latency window after its request, and flags early, late, spurious and abandoned handshakes. It sits passively beside any arbiter or slave port, and its registered error outputs feed the debug/status block.

## Interface
- NUM_CH, 4, number of monitored channels (1..32)
- MIN_LAT, 1, minimum legal req-to-gnt latency in cycles (0 allowed)
- MAX_LAT, 1, maximum legal latency; MAX_LAT ≥ MIN_LAT, MAX_LAT ≥ 1
- CNT_W, 16, width of the error counter
- clk  in  1  clock; all sampling on posedge
- rst  in  1  reset, synchronous, active-high
- req  in  NUM_CH  per-channel request level
- gnt  in  NUM_CH  per-channel grant level
- clr  in  1  clears err_sticky and err_cnt
- err_vld  out  1  one-cycle pulse: at least one violation detected
- err_ch  out  $clog2(NUM_CH) (min 1)  lowest violating channel index
- err_type  out  3  violation code of err_ch
- err_sticky  out  NUM_CH  per-channel "has ever violated" flags
- err_cnt  out  CNT_W  saturating total violation count

## Operation
- Per-channel FSM, states IDLE, WAIT, HELD. Latency counter k, width $clog2(MAX_LAT+1).
- k counts sampled edges since req was first seen high; the first high sample is k=0.
- IDLE:
  - req=1, gnt=1: if MIN_LAT=0 → HELD, else EARLY → HELD.
  - req=1, gnt=0: → WAIT, k=1.
  - req=0, gnt=1: SPURIOUS, stay IDLE.
- WAIT:
  - gnt=1: if k<MIN_LAT then EARLY, else OK; → HELD. Grant wins over a simultaneous req drop.
  - gnt=0, req=0: DROP → IDLE.
  - gnt=0, req=1, k=MAX_LAT: TIMEOUT → HELD.
  - otherwise k++.
- HELD (transaction closed; gnt may stay high): req=0 → IDLE. No errors are raised in HELD. A new request therefore needs req low for at least one sample.
- err_type codes: 0 none, 1 EARLY, 2 TIMEOUT, 3 DROP, 4 SPURIOUS. These are defined in the package.
- Multiple channels violating on the same edge:
  - err_ch/err_type report the lowest index.
  - err_sticky sets every violating bit.
  - err_cnt adds the popcount of violating channels and saturates at all-ones.
- clr coincident with new violations: clear first, then apply the new violations. The new ones survive.

## Timing
- Violation decided at sample edge N; err_vld/err_ch/err_type/err_sticky/err_cnt update at edge N+1. Fixed latency is 1 cycle.
- err_vld is high for exactly one cycle per violating edge. Back-to-back violations give back-to-back pulses.
- Reset values: err_vld=0, err_ch=0, err_type=0, err_sticky=0, err_cnt=0. All FSMs are IDLE with k=0.
- rst asserted mid-transaction aborts every FSM to IDLE and suppresses reporting on that edge. The first post-reset sample is treated as IDLE.
- MIN_LAT=MAX_LAT=1 is exactly "req implies gnt on next cycle".

## Configuration
- HS_MONITOR_SVA_EN defined: per-channel concurrent assertions are compiled in. They mirror the four checks, using the labels HS_EARLY, HS_TIMEOUT, HS_DROP and HS_SPURIOUS, are disabled iff rst, and call $error with the channel index. The RTL outputs are unchanged.
- HS_MONITOR_SVA_EN undefined: there are no assertions, and the block is pure synthesizable RTL.

## Structure
- The package hs_monitor_pkg holds:
  - the err_type_e enum (3-bit codes above);
  - the hs_state_e enum (IDLE/WAIT/HELD);
  - the constant HS_ERR_W=3.
- Sub-module hs_chan_fsm holds one channel FSM plus its latency counter and outputs a per-channel violation code. The top generates NUM_CH instances and adds the priority encoder, popcount, sticky and counter logic.

## Test plan
Defaults: NUM_CH=4, MIN_LAT=1, MAX_LAT=3.
- ch0: req rises at edge 2, gnt at edge 4 (k=2), req drops at edge 6 → err_vld never asserted, err_cnt=0.
- ch1: req and gnt rise together at edge 2 → err_vld=1 at edge 3, err_ch=1, err_type=1 (EARLY), err_sticky=4'b0010.
- ch2: req held high with no gnt from edge 2 → TIMEOUT detected at edge 5; err_vld at edge 6, err_type=2. No further errors while req stays high.
- ch3 and ch0 violate on the same edge: ch3 gets gnt with no req (SPURIOUS) while ch0 drops req in WAIT (DROP) → err_ch=0, err_type=3, err_sticky=4'b1001, err_cnt increments by 2.
- CNT_W=2, six SPURIOUS pulses → err_cnt saturates at 3. clr together with a violation → err_cnt=1 and only that channel's sticky bit is set.
- rst pulsed while ch2 is in WAIT with k=2 → no error reported. All outputs are 0 after the edge, and a compliant handshake afterwards is clean.
